// File: rtl/slit_multi_ch_tx_gen.sv
// N-channel framed test-pattern generator feeding the SiTCP TCP TX byte interface.
// Frames carry a 7-byte header, len payload words, and a 5A trailer. Channels are sent in ascending order.
module slit_multi_ch_tx_gen #(
   parameter int          N_CH       = 4,
   parameter int          DATA_BYTES = 4,
   parameter int          LEN_W      = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REG_WR_TRG,
   input  logic [LEN_W-1:0] REG_DATA_NUMBER,
   input  logic             REG_READY_ENB,
   input  logic [N_CH-1:0]  REG_CH_ENB,
   input  logic [6:0]       FLOW_DISABLE_RATE,
   input  logic [31:0]      MY_IP_ADDR,
   input  logic             TCP_TX_FULL,
   input  logic             NIM_IN,
   output logic             TCP_TX_WR,
   output logic [7:0]       TCP_TX_DATA,
   output logic             NIM_OUT,
   output logic             BUSY,
   output logic [15:0]      FRAME_CNT,
   output logic [2:0]       dbg_state
);

   localparam int         CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [1:0] LAST_B = 2'(DATA_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_PAY  = 3'd2,
      S_TRL  = 3'd3,
      S_NEXT = 3'd4
   } state_t;

   state_t                    state;
   logic [CH_W-1:0]           ch;
   logic [N_CH-1:0]           mask_q;
   logic [LEN_W-1:0]          len_q;
   logic [LEN_W-1:0]          word_idx;
   logic [2:0]                hdr_idx;
   logic [1:0]                byte_idx;
   logic [15:0]               frame_cnt;
   logic [15:0]               lfsr;
   logic [2:0]                nim_sync;
   logic                      nim_rise;
   logic                      trig;
   logic                      dis;
   logic                      issue;
   logic                      cnt_inc;
   logic [CH_W-1:0]           first_ch;
   logic [CH_W-1:0]           next_ch;
   logic                      next_found;
   logic [15:0]               len16;
   logic [31:0]               word_full;
   logic [8*DATA_BYTES-1:0]   word;
   logic [8*DATA_BYTES-1:0]   shifted;
   logic [7:0]                cur_byte;
   logic                      unused_ip;

   assign unused_ip = ^MY_IP_ADDR[31:8];
   assign dbg_state = state;
   assign FRAME_CNT = frame_cnt;

   // nim_sync[1] is the synchronised level, nim_sync[2] its previous value
   always_ff @(posedge CLK) begin
      if (RST) nim_sync <= '0;
      else     nim_sync <= {nim_sync[1:0], NIM_IN};
   end

   assign nim_rise = nim_sync[1] & ~nim_sync[2];
   assign trig     = REG_WR_TRG | nim_rise;

   always_ff @(posedge CLK) begin
      if (RST) lfsr <= LFSR_SEED;
      else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   assign dis     = (lfsr[6:0] < FLOW_DISABLE_RATE);
   assign issue   = ((state == S_HDR) || (state == S_PAY) || (state == S_TRL)) && !TCP_TX_FULL && !dis;
   assign cnt_inc = issue && (state == S_TRL);

   always_ff @(posedge CLK) begin
      if (RST) frame_cnt <= '0;
      else     frame_cnt <= frame_cnt + 16'(cnt_inc);
   end

   // Descending scan so the last hit is the lowest qualifying channel
   always_comb begin
      first_ch   = '0;
      next_ch    = '0;
      next_found = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (REG_CH_ENB[i]) first_ch = CH_W'(i);
         if (mask_q[i] && (i > int'(ch))) begin
            next_ch    = CH_W'(i);
            next_found = 1'b1;
         end
      end
   end

   assign len16     = 16'(len_q);
   assign word_full = {8'(ch), 24'(word_idx)};
   assign word      = word_full[8*DATA_BYTES-1:0];
   assign shifted   = word << {byte_idx, 3'b000};

   always_comb begin
      cur_byte = 8'h00;
      case (state)
         S_HDR: begin
            case (hdr_idx)
               3'd0:    cur_byte = 8'hA5;
               3'd1:    cur_byte = 8'(ch);
               3'd2:    cur_byte = MY_IP_ADDR[7:0];
               3'd3:    cur_byte = frame_cnt[15:8];
               3'd4:    cur_byte = frame_cnt[7:0];
               3'd5:    cur_byte = len16[15:8];
               default: cur_byte = len16[7:0];
            endcase
         end
         S_PAY:   cur_byte = shifted[8*DATA_BYTES-1 -: 8];
         S_TRL:   cur_byte = 8'h5A;
         default: cur_byte = 8'h00;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         ch          <= '0;
         mask_q      <= '0;
         len_q       <= '0;
         hdr_idx     <= '0;
         word_idx    <= '0;
         byte_idx    <= '0;
         TCP_TX_WR   <= 1'b0;
         TCP_TX_DATA <= 8'h00;
         BUSY        <= 1'b0;
         NIM_OUT     <= 1'b0;
      end else begin
         TCP_TX_WR <= issue;
         if (issue) TCP_TX_DATA <= cur_byte;
         case (state)
            S_IDLE: begin
               if (trig && REG_READY_ENB && (REG_CH_ENB != '0)) begin
                  len_q   <= REG_DATA_NUMBER;
                  mask_q  <= REG_CH_ENB;
                  ch      <= first_ch;
                  hdr_idx <= '0;
                  state   <= S_HDR;
                  BUSY    <= 1'b1;
                  NIM_OUT <= 1'b1;
               end
            end
            S_HDR: begin
               if (issue) begin
                  if (hdr_idx == 3'd6) begin
                     hdr_idx  <= '0;
                     word_idx <= '0;
                     byte_idx <= '0;
                     state    <= (len_q == '0) ? S_TRL : S_PAY;
                  end else begin
                     hdr_idx <= hdr_idx + 3'd1;
                  end
               end
            end
            S_PAY: begin
               if (issue) begin
                  if (byte_idx == LAST_B) begin
                     byte_idx <= '0;
                     if (word_idx == len_q - LEN_W'(1)) state <= S_TRL;
                     else                               word_idx <= word_idx + LEN_W'(1);
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            S_TRL: begin
               if (issue) state <= S_NEXT;
            end
            S_NEXT: begin
               // Losing READY only stops the burst between frames
               if (REG_READY_ENB && next_found) begin
                  ch    <= next_ch;
                  state <= S_HDR;
               end else begin
                  state   <= S_IDLE;
                  BUSY    <= 1'b0;
                  NIM_OUT <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
